fifo_rr_drain: RTL

- Round-robin read scheduler that drains NREQ synchronous FIFOs into one ready/valid output stream, tagging each word with its source index.
- Each FIFO has one-cycle read latency: rd_data and ne update one clock after re.
- Sits between per-channel capture FIFOs and the shared packetizer/DMA path.
- Never causes FIFO underflow; absorbs read latency with an internal 2-entry skid buffer.

---
 rtl/fifo_rr_drain.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/fifo_rr_drain.sv
// -----------------------------------------------------------------------------
// fifo_rr_drain
//
// Round-robin read scheduler that drains NREQ synchronous FIFOs (one-cycle
// read latency) into a single ready/valid stream. Each output word carries
// the index of the FIFO it came from. A 2-entry skid buffer absorbs the read
// latency, so one word per clock is sustained while out_ready stays high.
//
// Ports:
//   clk           clock
//   reset         asynchronous, active-high reset
//   fifo_ne       per-FIFO not-empty flags
//   fifo_re       per-FIFO read enables (one-hot or zero, combinational)
//   fifo_rd_data  packed read data, FIFO i at [i*DATAWIDTH +: DATAWIDTH]
//   out_data      output word
//   out_src       source FIFO index of out_data
//   out_valid     output word valid
//   out_ready     downstream accept
//   busy          granting, or a word is in flight or buffered
//
// Build option:
//   FIFO_DRAIN_PRIO0_EN  requester 0 gets strict priority and drains without
//                        a burst limit; the others share round-robin.
// -----------------------------------------------------------------------------
module fifo_rr_drain #(
   parameter int NREQ      = 4,
   parameter int SRCWIDTH  = 2,
   parameter int DATAWIDTH = 18,
   parameter int BURST     = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NREQ-1:0]           fifo_ne,
   output logic [NREQ-1:0]           fifo_re,
   input  logic [NREQ*DATAWIDTH-1:0] fifo_rd_data,
   output logic [DATAWIDTH-1:0]      out_data,
   output logic [SRCWIDTH-1:0]       out_src,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      busy
);

   localparam logic [0:0]          ST_IDLE  = 1'b0;
   localparam logic [0:0]          ST_GRANT = 1'b1;
   localparam logic [7:0]          BURST_C  = 8'(BURST);
   localparam logic [SRCWIDTH-1:0] SRC_ZERO = {SRCWIDTH{1'b0}};
   localparam logic [SRCWIDTH-1:0] LAST_RST = SRCWIDTH'(NREQ - 1);
   localparam logic [NREQ-1:0]     RE_ONE   = {{(NREQ-1){1'b0}}, 1'b1};

   logic [0:0]          state_q, state_d;
   logic [SRCWIDTH-1:0] grant_q, grant_d;
   logic [SRCWIDTH-1:0] last_q, last_d;
   logic [7:0]          bcnt_q, bcnt_d;
   logic                inflight_q, inflight_d;
   logic [SRCWIDTH-1:0] inflight_src_q, inflight_src_d;
   logic [1:0]          occ_q, occ_d;
   logic [DATAWIDTH-1:0] hd_data_q, hd_data_d, tl_data_q, tl_data_d;
   logic [SRCWIDTH-1:0] hd_src_q, hd_src_d, tl_src_q, tl_src_d;
   logic                valid_q, valid_d;
   logic                busy_q, busy_d;

   int                  cand_s;
   logic                hit_s;
   logic                rr_found_s;
   logic [SRCWIDTH-1:0] rr_idx_s;
   logic                prio_pick_s;
   logic                prio_grant_s;
   logic                pick_found_s;
   logic [SRCWIDTH-1:0] pick_idx_s;
   logic [SRCWIDTH-1:0] pick_last_s;
   logic                ne_g_s;
   logic                pop_s;
   logic                space_s;
   logic                re_any_s;
   logic [DATAWIDTH-1:0] push_data_s;

   // Rotating search for the first non-empty FIFO after the last grantee.
   always_comb begin
      cand_s     = 0;
      hit_s      = 1'b0;
      rr_found_s = 1'b0;
      rr_idx_s   = SRC_ZERO;
      for (int k = 1; k <= NREQ; k++) begin
         cand_s     = (int'(last_q) + k) % NREQ;
         hit_s      = (|(fifo_ne & (RE_ONE << cand_s))) & ~rr_found_s;
         rr_idx_s   = hit_s ? SRCWIDTH'(cand_s) : rr_idx_s;
         rr_found_s = rr_found_s | hit_s;
      end
   end

`ifdef FIFO_DRAIN_PRIO0_EN
   assign prio_pick_s  = fifo_ne[0];
   assign prio_grant_s = (grant_q == SRC_ZERO);
`else
   assign prio_pick_s  = 1'b0;
   assign prio_grant_s = 1'b0;
`endif

   // A priority pick of requester 0 leaves the round-robin pointer untouched.
   assign pick_found_s = prio_pick_s | rr_found_s;
   assign pick_idx_s   = prio_pick_s ? SRC_ZERO : rr_idx_s;
   assign pick_last_s  = prio_pick_s ? last_q : rr_idx_s;

   // Read issue: only for the grantee, only while it has data, burst budget
   // and room for the word once it lands (buffered + in flight - leaving <= 1).
   assign ne_g_s   = |(fifo_ne & (RE_ONE << grant_q));
   assign pop_s    = valid_q & out_ready;
   assign space_s  = (({1'b0, occ_q} + {2'b00, inflight_q}) - {2'b00, pop_s}) <= 3'd1;
   assign re_any_s = (state_q == ST_GRANT) & ne_g_s
                     & ((bcnt_q < BURST_C) | prio_grant_s) & space_s;
   assign fifo_re  = re_any_s ? (RE_ONE << grant_q) : {NREQ{1'b0}};

   // Word returned by the FIFO read issued on the previous cycle.
   assign push_data_s = DATAWIDTH'(fifo_rd_data >> (int'(inflight_src_q) * DATAWIDTH));

   // Grant state machine next-state logic.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      bcnt_d  = bcnt_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_found_s) begin
               state_d = ST_GRANT;
               grant_d = pick_idx_s;
               last_d  = pick_last_s;
               bcnt_d  = 8'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (re_any_s) begin
               bcnt_d = bcnt_q + 8'd1;
               if ((bcnt_d == BURST_C) && !prio_grant_s) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_GRANT;
               end
            end else if (!ne_g_s) begin
               state_d = ST_IDLE;
            end else begin
               // stalled for space only: keep the grant
               state_d = ST_GRANT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Skid buffer next-state: head entry drives the output, tail holds overflow.
   always_comb begin
      inflight_d     = re_any_s;
      inflight_src_d = grant_q;
      occ_d          = occ_q;
      hd_data_d      = hd_data_q;
      hd_src_d       = hd_src_q;
      tl_data_d      = tl_data_q;
      tl_src_d       = tl_src_q;
      case ({inflight_q, pop_s})
         2'b10: begin
            occ_d = occ_q + 2'd1;
            if (occ_q == 2'd0) begin
               hd_data_d = push_data_s;
               hd_src_d  = inflight_src_q;
            end else begin
               tl_data_d = push_data_s;
               tl_src_d  = inflight_src_q;
            end
         end
         2'b01: begin
            occ_d     = occ_q - 2'd1;
            hd_data_d = tl_data_q;
            hd_src_d  = tl_src_q;
         end
         2'b11: begin
            if (occ_q == 2'd1) begin
               hd_data_d = push_data_s;
               hd_src_d  = inflight_src_q;
            end else begin
               hd_data_d = tl_data_q;
               hd_src_d  = tl_src_q;
               tl_data_d = push_data_s;
               tl_src_d  = inflight_src_q;
            end
         end
         default: begin
            occ_d = occ_q;
         end
      endcase
      valid_d = (occ_d != 2'd0);
      busy_d  = (state_d == ST_GRANT) | inflight_d | (occ_d != 2'd0);
   end

   // State, skid buffer and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         grant_q        <= SRC_ZERO;
         last_q         <= LAST_RST;
         bcnt_q         <= 8'd0;
         inflight_q     <= 1'b0;
         inflight_src_q <= SRC_ZERO;
         occ_q          <= 2'd0;
         hd_data_q      <= {DATAWIDTH{1'b0}};
         hd_src_q       <= SRC_ZERO;
         tl_data_q      <= {DATAWIDTH{1'b0}};
         tl_src_q       <= SRC_ZERO;
         valid_q        <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         grant_q        <= grant_d;
         last_q         <= last_d;
         bcnt_q         <= bcnt_d;
         inflight_q     <= inflight_d;
         inflight_src_q <= inflight_src_d;
         occ_q          <= occ_d;
         hd_data_q      <= hd_data_d;
         hd_src_q       <= hd_src_d;
         tl_data_q      <= tl_data_d;
         tl_src_q       <= tl_src_d;
         valid_q        <= valid_d;
         busy_q         <= busy_d;
      end
   end

   assign out_data  = hd_data_q;
   assign out_src   = hd_src_q;
   assign out_valid = valid_q;
   assign busy      = busy_q;

endmodule
